// File: rtl/jk_stim_pkg.sv
// Shared types and constants for the JK flip-flop stimulus controller.
package jk_stim_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HIGH  = 2'd2,
        LOW   = 2'd3
    } step_state_t;

    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/jk_stimulus_ctrl_if.sv
// Board-side pins of the stimulus controller: raw buttons/switch in, conditioned J/K/step clock out.
interface jk_stimulus_ctrl_if;

    logic J_BTN;
    logic K_BTN;
    logic STEP_BTN;
    logic AUTO_EN;
    logic J;
    logic K;
    logic STEP_CLK;
    logic BUSY;

    modport master (
        output J_BTN, K_BTN, STEP_BTN, AUTO_EN,
        input  J, K, STEP_CLK, BUSY
    );

    modport slave (
        input  J_BTN, K_BTN, STEP_BTN, AUTO_EN,
        output J, K, STEP_CLK, BUSY
    );

endinterface

// File: rtl/jk_stimulus_ctrl_btn_debounce.sv
// Two-flop synchronizer followed by a counting debouncer for one raw pushbutton.
module btn_debounce
    import jk_stim_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic RAW,
    output logic LEVEL
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   level_q, level_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], RAW};
        level_d = level_q;
        cnt_d   = '0;
        // Any sample agreeing with the current level restarts the stability count.
        if (sync_q[SYNC_STAGES-1] != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign LEVEL = level_q;

endmodule

// File: rtl/jk_stimulus_ctrl.sv
// Conditions the J/K/STEP buttons and AUTO switch, and sequences single-step clock pulses.
module jk_stimulus_ctrl
    import jk_stim_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int STEP_HIGH       = 4,
    parameter int AUTO_DIV        = 1000
) (
    input  logic               CLK,
    input  logic               RST_N,
    jk_stimulus_ctrl_if.slave  io
);

    localparam int PRE_W = $clog2(AUTO_DIV);
    localparam int PH_W  = $clog2(STEP_HIGH + 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(AUTO_DIV - 1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(STEP_HIGH - 1);

    logic j_lvl, k_lvl, step_lvl;

    logic [SYNC_STAGES-1:0] auto_sync_q, auto_sync_d;
    logic                   step_dly_q, step_dly_d;
    logic [PRE_W-1:0]       presc_q, presc_d;
    step_state_t            state_q, state_d;
    logic [PH_W-1:0]        ph_q, ph_d;
    logic                   pend_q, pend_d;
    logic                   j_q, j_d, k_q, k_d;
    logic                   step_clk_q, step_clk_d;
    logic                   busy_q, busy_d;
    logic                   manual_trig, auto_tick;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_j (
        .CLK(CLK), .RST_N(RST_N), .RAW(io.J_BTN), .LEVEL(j_lvl)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_k (
        .CLK(CLK), .RST_N(RST_N), .RAW(io.K_BTN), .LEVEL(k_lvl)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_step (
        .CLK(CLK), .RST_N(RST_N), .RAW(io.STEP_BTN), .LEVEL(step_lvl)
    );

    always_comb begin
        auto_sync_d = {auto_sync_q[SYNC_STAGES-2:0], io.AUTO_EN};
        step_dly_d  = step_lvl;
        manual_trig = step_lvl & ~step_dly_q;
        auto_tick   = 1'b0;
        presc_d     = '0;
        if (auto_sync_q[SYNC_STAGES-1]) begin
            if (presc_q == PRE_LAST) begin
                auto_tick = 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        pend_d  = pend_q;
        j_d     = j_q;
        k_d     = k_q;
        case (state_q)
            IDLE: begin
                j_d = j_lvl;
                k_d = k_lvl;
                if (manual_trig || auto_tick || pend_q) begin
                    state_d = SETUP;
                    pend_d  = 1'b0;
                end
            end
            SETUP: begin
                state_d = HIGH;
                ph_d    = '0;
            end
            HIGH: begin
                if (ph_q == PH_LAST) begin
                    state_d = LOW;
                    ph_d    = '0;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            LOW: begin
                if (ph_q == PH_LAST) begin
                    state_d = IDLE;
                    ph_d    = '0;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Only manual presses queue up; auto ticks during a step are simply lost.
        if (state_q != IDLE && manual_trig) begin
            pend_d = 1'b1;
        end
        // Outputs decoded from the next state so STEP_CLK comes straight off a flop.
        step_clk_d = (state_d == HIGH);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            auto_sync_q <= '0;
            step_dly_q  <= 1'b0;
            presc_q     <= '0;
            state_q     <= IDLE;
            ph_q        <= '0;
            pend_q      <= 1'b0;
            j_q         <= 1'b0;
            k_q         <= 1'b0;
            step_clk_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            auto_sync_q <= auto_sync_d;
            step_dly_q  <= step_dly_d;
            presc_q     <= presc_d;
            state_q     <= state_d;
            ph_q        <= ph_d;
            pend_q      <= pend_d;
            j_q         <= j_d;
            k_q         <= k_d;
            step_clk_q  <= step_clk_d;
            busy_q      <= busy_d;
        end
    end

    assign io.J        = j_q;
    assign io.K        = k_q;
    assign io.STEP_CLK = step_clk_q;
    assign io.BUSY     = busy_q;

endmodule

// File: tb/tb_jk_stimulus_ctrl.sv
// Scoreboard bench for jk_stimulus_ctrl: a window/arithmetic reference model predicts each step.
module tb_jk_stimulus_ctrl;
    import jk_stim_pkg::*;

    localparam int DEB = 4;
    localparam int SH  = 2;
    localparam int DIV = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    jk_stimulus_ctrl_if bus();

    jk_stimulus_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .STEP_HIGH(SH),
        .AUTO_DIV(DIV)
    ) dut (
        .CLK(clk),
        .RST_N(rst_n),
        .io(bus)
    );

    typedef struct {
        int s;
        bit j;
        bit k;
    } step_t;

    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    int    n_rises = 0;
    step_t exp_q[$];
    bit    exp_j, exp_k;

    // reference model state
    bit hj[$], hk[$], hs[$], ha[$];
    bit lj, lk, ls, ls_prev;
    int arun;
    int next_ok;
    bit pend;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, req, cyc);
        end
    endtask

    // A debounced level flips once the last DEB synchronized samples all disagree with it.
    function automatic bit settles(input bit h[$], input bit lvl);
        for (int i = 0; i < DEB; i++) begin
            if (h[h.size() - 3 - i] == lvl) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        hj.delete(); hk.delete(); hs.delete(); ha.delete();
        for (int i = 0; i < DEB + 3; i++) begin
            hj.push_back(1'b0); hk.push_back(1'b0);
            hs.push_back(1'b0); ha.push_back(1'b0);
        end
        lj = 0; lk = 0; ls = 0; ls_prev = 0;
        arun = 0; next_ok = 0; pend = 0;
        exp_j = 0; exp_k = 0;
        exp_q.delete();
    endtask

    task automatic model_edge();
        bit manual, tick, a_s;
        hj.push_back(bus.J_BTN);    void'(hj.pop_front());
        hk.push_back(bus.K_BTN);    void'(hk.pop_front());
        hs.push_back(bus.STEP_BTN); void'(hs.pop_front());
        ha.push_back(bus.AUTO_EN);  void'(ha.pop_front());
        manual = ls && !ls_prev;
        a_s    = ha[ha.size() - 3];
        if (a_s) arun++; else arun = 0;
        tick = a_s && (arun % DIV == 0);
        if (cyc >= next_ok) begin
            exp_j = lj;
            exp_k = lk;
            if (manual || tick || pend) begin
                exp_q.push_back('{cyc, lj, lk});
                pend    = 0;
                next_ok = cyc + 2 + 2 * SH;
            end
        end else if (manual) begin
            pend = 1;
        end
        ls_prev = ls;
        if (settles(hj, lj)) lj = !lj;
        if (settles(hk, lk)) lk = !lk;
        if (settles(hs, ls)) ls = !ls;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) model_reset();
            else        model_edge();
        end
    end

    // monitor: pops one expectation per step when BUSY rises
    initial begin
        step_t e;
        bit in_step = 0;
        bit pb = 0;
        bit pc = 0;
        e = '{0, 1'b0, 1'b0};
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_step = 0; pb = 0; pc = 0;
            end else begin
                check("j_level", bus.J, exp_j);
                check("k_level", bus.K, exp_k);
                if (bus.STEP_CLK && !pc) n_rises++;
                if (bus.BUSY && !pb) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_step", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        in_step = 1;
                        check("busy_rise_edge", cyc, e.s);
                    end
                end
                if (in_step) begin
                    if (bus.STEP_CLK && !pc) begin
                        check("clk_rise_edge", cyc, e.s + 1);
                        check("j_at_rise", bus.J, e.j);
                        check("k_at_rise", bus.K, e.k);
                    end
                    if (!bus.STEP_CLK && pc) check("clk_fall_edge", cyc, e.s + 1 + SH);
                    if (!bus.BUSY && pb) begin
                        check("busy_fall_edge", cyc, e.s + 1 + 2 * SH);
                        in_step = 0;
                    end
                end else if (bus.STEP_CLK && !pc) begin
                    check("stray_step_clk", 1, 0);
                end
                pb = bus.BUSY;
                pc = bus.STEP_CLK;
            end
        end
    end

    initial begin
        int r0;
        int hold[4];
        bit seen;
        bus.J_BTN = 0; bus.K_BTN = 0; bus.STEP_BTN = 0; bus.AUTO_EN = 0;
        rst_n = 0;
        #1;
        check("rst_J", bus.J, 0);
        check("rst_K", bus.K, 0);
        check("rst_STEP_CLK", bus.STEP_CLK, 0);
        check("rst_BUSY", bus.BUSY, 0);
        repeat (3) @(negedge clk);
        rst_n = 1;
        repeat (4) @(negedge clk);

        // bounce shorter than the debounce window
        for (int i = 0; i < 6; i++) begin
            bus.J_BTN = (i % 2 == 0);
            repeat (2) @(negedge clk);
        end
        bus.J_BTN = 0;
        repeat (10) @(negedge clk);
        check("bounce_J", bus.J, 0);

        // clean step
        bus.J_BTN = 1;
        repeat (10) @(negedge clk);
        check("clean_J", bus.J, 1);
        bus.STEP_BTN = 1;
        repeat (8) @(negedge clk);
        bus.STEP_BTN = 0;
        repeat (20) @(negedge clk);

        // K changes while the step is in flight
        bus.STEP_BTN = 1;
        @(negedge clk);
        bus.K_BTN = 1;
        repeat (8) @(negedge clk);
        bus.STEP_BTN = 0;
        repeat (20) @(negedge clk);
        check("freeze_K_after", bus.K, 1);

        // auto mode for 40 cycles
        r0 = n_rises;
        bus.AUTO_EN = 1;
        repeat (40) @(negedge clk);
        bus.AUTO_EN = 0;
        repeat (20) @(negedge clk);
        check("auto_pulses", n_rises - r0, 4);
        check("auto_presc_zero", int'(dut.presc_q), 0);

        // manual press landing inside an auto step becomes a pending step
        r0 = n_rises;
        bus.AUTO_EN = 1;
        repeat (7) @(negedge clk);
        bus.STEP_BTN = 1;
        repeat (6) @(negedge clk);
        bus.STEP_BTN = 0;
        bus.AUTO_EN = 0;
        repeat (25) @(negedge clk);
        check("pending_pulses", n_rises - r0, 2);

        // reset while STEP_CLK is high
        bus.STEP_BTN = 1;
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            seen = bus.STEP_CLK;
        end
        check("pulse_before_reset", seen, 1);
        #2;
        rst_n = 0;
        #1;
        check("midrst_STEP_CLK", bus.STEP_CLK, 0);
        check("midrst_BUSY", bus.BUSY, 0);
        check("midrst_J", bus.J, 0);
        check("midrst_K", bus.K, 0);
        check("midrst_state_idle", (dut.state_q == IDLE) ? 1 : 0, 1);
        bus.STEP_BTN = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        repeat (4) @(negedge clk);

        // randomized button and switch activity
        for (int b = 0; b < 4; b++) hold[b] = $urandom_range(1, 12);
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            for (int b = 0; b < 4; b++) begin
                if (hold[b] == 0) begin
                    case (b)
                        0: bus.J_BTN    = ~bus.J_BTN;
                        1: bus.K_BTN    = ~bus.K_BTN;
                        2: bus.STEP_BTN = ~bus.STEP_BTN;
                        default: bus.AUTO_EN = ~bus.AUTO_EN;
                    endcase
                    hold[b] = (b == 3) ? $urandom_range(20, 80) : $urandom_range(1, 12);
                end else begin
                    hold[b]--;
                end
            end
        end
        bus.J_BTN = 0; bus.K_BTN = 0; bus.STEP_BTN = 0; bus.AUTO_EN = 0;
        repeat (40) @(negedge clk);
        check("all_steps_seen", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jk_stimulus_ctrl.md
# jk_stimulus_ctrl

Upstream driver for the lab JK flip-flop. It conditions three board pushbuttons (J, K, STEP) and one slide switch (AUTO), and produces clean, stable J/K levels plus a well-formed single-step clock pulse, `STEP_CLK`, which feeds the flip-flop's `CLK`. J and K never change while a step pulse is in flight. Steps come either from a STEP button press or from a free-running prescaler in auto mode.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronized samples required before a debounced level changes; must be ≥1.
- `STEP_HIGH`, default 4: width of the `STEP_CLK` high phase in CLK cycles; the low recovery phase has the same width; must be ≥1.
- `AUTO_DIV`, default 1000: auto-step period in CLK cycles; must be ≥ 2*STEP_HIGH+2.
- `CLK` input 1: system clock; all state updates on its rising edge.
- `RST_N` input 1: asynchronous, active-low reset.
- `J_BTN` input 1: raw, asynchronous J pushbutton.
- `K_BTN` input 1: raw, asynchronous K pushbutton.
- `STEP_BTN` input 1: raw, asynchronous step pushbutton.
- `AUTO_EN` input 1: raw slide switch; 1 selects auto stepping.
- `J` output 1: registered J level to the flip-flop.
- `K` output 1: registered K level to the flip-flop.
- `STEP_CLK` output 1: registered step clock to the flip-flop.
- `BUSY` output 1: high while a step is in progress (any state other than IDLE).

## Operation
- **Reset** (`RST_N`=0, takes effect immediately):
  - `J`=`K`=`STEP_CLK`=`BUSY`=0.
  - All synchronizers, debounced levels and counters are cleared; the pending flag is cleared.
  - FSM goes to IDLE.
  - Reset asserted mid-pulse drops `STEP_CLK` without completing the step.
- **Conditioning:**
  - Each button passes through a 2-flop synchronizer, then a debouncer.
  - The debouncer's counter increments while the synchronized value differs from the debounced level, and clears otherwise.
  - When the counter reaches `DEBOUNCE_CYCLES`, the debounced level flips and the counter clears.
  - `AUTO_EN` is synchronized only; it is not debounced.
- **Step triggers:**
  - Manual: a rising edge of debounced STEP (debounced level vs. its one-cycle-delayed copy).
  - Auto: the prescaler counts 0..`AUTO_DIV`-1 while synced AUTO=1, and is held at 0 while synced AUTO=0. A tick fires on the wrap to 0.
- **FSM states:** IDLE, SETUP, HIGH, LOW.
  - IDLE → SETUP on any trigger or on the pending flag; the flag is cleared on this transition.
  - SETUP → HIGH after 1 cycle.
  - HIGH → LOW after `STEP_HIGH` cycles.
  - LOW → IDLE after `STEP_HIGH` cycles.
- **Outputs:**
  - `J`/`K` load their debounced levels on every edge where the current state is IDLE; in all other states they hold. The values sampled on the IDLE→SETUP edge are therefore frozen for the whole step.
  - `STEP_CLK`=1 exactly in HIGH; `BUSY`=1 in SETUP, HIGH and LOW.
- **Boundary conditions:**
  - Manual trigger and auto tick on the same edge produce one step.
  - A manual trigger while `BUSY` sets a one-deep pending flag; further manual triggers while the flag is set are dropped.
  - Auto ticks while `BUSY` are dropped.
  - A button bounce shorter than `DEBOUNCE_CYCLES` produces no change.

## Timing
- Raw button change to debounced change: 2 + `DEBOUNCE_CYCLES` edges, provided the input is stable.
- Step sequence, with debounced STEP rising at edge t:
  - SETUP and `BUSY`=1 at edge t+1.
  - `STEP_CLK`=1 from edge t+2 to edge t+2+`STEP_HIGH`.
  - IDLE and `BUSY`=0 at edge t+2+2*`STEP_HIGH`.
- A pending step starts on the edge `BUSY` falls (LOW→IDLE), then enters SETUP one edge later.
- `J`/`K` setup before `STEP_CLK` rises: ≥1 CLK cycle. `J`/`K` hold after `STEP_CLK` falls: ≥`STEP_HIGH` cycles.

## Structure
- Package `jk_stim_pkg` holds:
  - the state enum `step_state_t` (IDLE, SETUP, HIGH, LOW);
  - the constant `SYNC_STAGES`=2.
- Sub-module `btn_debounce` (synchronizer plus debouncer, parameter `DEBOUNCE_CYCLES`, ports `CLK`, `RST_N`, `RAW`, `LEVEL`) is instantiated three times.
- The top level contains the AUTO synchronizer, the edge detect, the prescaler, the FSM and the output registers.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `STEP_HIGH`=2, `AUTO_DIV`=10.
- **Bounce rejection:** `J_BTN` toggles 1/0 every 2 cycles for 12 cycles, then holds at 0 → `J` stays 0 throughout.
- **Clean step:** `J_BTN`=1 and `K_BTN`=0 held, then a `STEP_BTN` press → `J`=1, `K`=0 before `STEP_CLK` rises; `STEP_CLK` high exactly 2 cycles; `BUSY` high exactly 5 cycles.
- **Freeze:** `K_BTN` changes to 1 during HIGH → `K` stays 0 until IDLE, then updates to 1.
- **Pending:** two STEP presses whose debounced edges are 3 cycles apart → two complete pulses, the second entering SETUP 1 cycle after `BUSY` falls; a third press during the first step is dropped.
- **Auto mode:** `AUTO_EN`=1 for 40 cycles → 4 pulses 10 cycles apart; `AUTO_EN`=0 → no further pulses, and the prescaler reads 0.
- **Reset mid-pulse:** `RST_N`=0 while `STEP_CLK`=1 → `STEP_CLK`, `BUSY`, `J` and `K` go to 0 without waiting for an edge; FSM returns to IDLE.
